// File: rtl/riscky_pkg.sv
// Shared definitions for the instruction front end.
// XLEN / INSTR_W : architectural and instruction word widths.
// NOP            : canonical no-op encoding (addi x0,x0,0).
// fetch_entry_t  : one instruction-queue entry, instruction word plus its PC.
package riscky_pkg;
   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [XLEN-1:0]    pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: circular buffer of DEPTH entries of WIDTH bits.
// Ports: clk_i, rst_ni (async active-low), push_i/push_data_i, pop_i,
//        flush_i (empties the queue, wins over push and pop),
//        head_o (zero while empty), empty_o, count_o (occupancy).
module fetch_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   // A push into a full queue is only legal when the head leaves the same cycle.
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
   // Storage is not reset, so mask it while empty to keep the outputs clean.
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end
endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: streams sequential fetches to instruction memory,
// queues returned words with their PCs, and handles redirects by flushing
// the queue and discarding responses to requests already in flight.
// Ports: clk, rst (async active-low), redirect_valid/redirect_pc,
//        imem_req_valid/imem_req_ready/imem_addr (request channel),
//        imem_rsp_valid/imem_rsp_data (in-order responses),
//        instr_valid/instr_ready/instr_out/pc_out (toward decode).
module instruction_prefetch
   import riscky_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [XLEN-1:0]    pc_out
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;    // PC of the next response we keep
   logic [CW-1:0]   out_q, out_d;          // requests in flight (kept + dropped)
   logic [CW-1:0]   drop_q, drop_d;        // in-flight responses still to discard
   logic [CW-1:0]   fifo_cnt;
   logic [CW:0]     inflight;
   logic            fifo_empty, req_fire, rsp_acc, rsp_push;
   fetch_entry_t    push_entry, head;

   // Queue slots are reserved at request time, so the queue can never overflow.
   assign inflight       = {1'b0, fifo_cnt} + {1'b0, out_q};
   assign imem_req_valid = rst && !redirect_valid && (inflight < (CW+1)'(DEPTH));
   assign imem_addr      = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   // Responses with nothing outstanding are stray (e.g. from before a reset).
   assign rsp_acc        = imem_rsp_valid && (out_q != '0);
   assign rsp_push       = rsp_acc && (drop_q == '0) && !redirect_valid;

   assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      out_d      = out_q + CW'(req_fire) - CW'(rsp_acc);
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'd3;
         rsp_pc_d   = redirect_pc & ~32'd3;
         // Everything still in flight after this cycle is stale, including
         // requests already marked by an earlier redirect.
         drop_d     = out_q - CW'(rsp_acc);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_push) rsp_pc_d   = rsp_pc_q + 32'd4;
         if (rsp_acc && (drop_q != '0)) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W + XLEN)) u_fifo (
      .clk_i       (clk),
      .rst_ni      (rst),
      .push_i      (rsp_push),
      .push_data_i (push_entry),
      .pop_i       (instr_valid && instr_ready),
      .flush_i     (redirect_valid),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_cnt)
   );

   assign instr_valid = !fifo_empty;
   assign instr_out   = head.instr;
   assign pc_out      = head.pc;
endmodule
